muldiv_hilo_ctrl: RTL



---
 rtl/muldiv_hilo_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns the architectural HI/LO registers.
// Optional macro MULDIV_EARLY_OUT_EN: a divide with |dividend| < |divisor| skips iteration.
module muldiv_hilo_ctrl #(
    parameter int MUL_LAT   = 2,
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        mul,
    input  logic        div,
    input  logic        mul_signed,
    input  logic        div_signed,
    input  logic        HI_write,
    input  logic        LO_write,
    input  logic [1:0]  HI_MemtoReg,
    input  logic [1:0]  LO_MemtoReg,
    input  logic        mf_hi,
    input  logic        mf_lo,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // state   | meaning
    // IDLE    | waiting; accepts mul/div issue and MTHI/MTLO writes
    // MUL_RUN | registered multiplier running, MUL_LAT cycles
    // DIV_RUN | restoring divider, one quotient bit per cycle
    // WB      | done pulse; HI/LO written at the end of this cycle
    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, WB} state_t;

    localparam logic [5:0] MUL_TC_LOAD = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_TC_LOAD = 6'(DIV_ITERS - 1);

    state_t      state;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        mul_sgn;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;
    logic        hi_we;
    logic        lo_we;
    logic [1:0]  hi_sel;
    logic [1:0]  lo_sel;
    logic [5:0]  cnt;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [63:0] prod;

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod_full;
    logic [32:0] div_trial;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] hi_val;
    logic [31:0] lo_val;

    assign stall = op_valid & busy & (mul | div | mf_hi | mf_lo | HI_write | LO_write);

    assign mag_a = (div_signed & src_a[31]) ? (32'd0 - src_a) : src_a;
    assign mag_b = (div_signed & src_b[31]) ? (32'd0 - src_b) : src_b;

    // Sign- or zero-extend to 64 bits so one multiplier covers MULT and MULTU.
    assign ext_a     = mul_sgn ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
    assign ext_b     = mul_sgn ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
    assign prod_full = ext_a * ext_b;

    assign div_trial = {rem, quo[31]} - {1'b0, op_b};

    assign quo_fix = neg_q ? (32'd0 - quo) : quo;
    assign rem_fix = neg_r ? (32'd0 - rem) : rem;

    always_comb begin
        hi_val = op_a;
        case (hi_sel)
            2'b00:   hi_val = prod[63:32];
            2'b01:   hi_val = rem_fix;
            default: hi_val = op_a;
        endcase
    end

    always_comb begin
        lo_val = op_a;
        case (lo_sel)
            2'b00:   lo_val = prod[31:0];
            2'b01:   lo_val = quo_fix;
            default: lo_val = op_a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            op_a     <= 32'd0;
            op_b     <= 32'd0;
            mul_sgn  <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi_we    <= 1'b0;
            lo_we    <= 1'b0;
            hi_sel   <= 2'b00;
            lo_sel   <= 2'b00;
            cnt      <= 6'd0;
            rem      <= 32'd0;
            quo      <= 32'd0;
            prod     <= 64'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!cancel) begin
                        if (op_valid & (mul | div)) begin
                            op_a     <= src_a;
                            op_b     <= mul ? src_b : mag_b;
                            mul_sgn  <= mul_signed;
                            neg_q    <= div_signed & (src_a[31] ^ src_b[31]);
                            neg_r    <= div_signed & src_a[31];
                            hi_we    <= HI_write;
                            lo_we    <= LO_write;
                            hi_sel   <= HI_MemtoReg;
                            lo_sel   <= LO_MemtoReg;
                            div_zero <= 1'b0;
                            busy     <= 1'b1;
                            if (mul) begin
                                cnt   <= MUL_TC_LOAD;
                                state <= MUL_RUN;
                            end else if (src_b == 32'd0) begin
                                div_zero <= 1'b1;
                                done     <= 1'b1;
                                state    <= WB;
`ifdef MULDIV_EARLY_OUT_EN
                            end else if (mag_a < mag_b) begin
                                // Quotient is zero; remainder magnitude is the dividend itself.
                                quo   <= 32'd0;
                                rem   <= mag_a;
                                done  <= 1'b1;
                                state <= WB;
`endif
                            end else begin
                                quo   <= mag_a;
                                rem   <= 32'd0;
                                cnt   <= DIV_TC_LOAD;
                                state <= DIV_RUN;
                            end
                        end else begin
                            if (op_valid & HI_write & (HI_MemtoReg == 2'b10)) hi <= src_a;
                            if (op_valid & LO_write & (LO_MemtoReg == 2'b10)) lo <= src_a;
                        end
                    end
                end
                MUL_RUN: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        prod <= prod_full;
                        if (cnt == 6'd0) begin
                            done  <= 1'b1;
                            state <= WB;
                        end else begin
                            cnt <= cnt - 6'd1;
                        end
                    end
                end
                DIV_RUN: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (!div_trial[32]) begin
                            rem <= div_trial[31:0];
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= {rem[30:0], quo[31]};
                            quo <= {quo[30:0], 1'b0};
                        end
                        if (cnt == 6'd0) begin
                            done  <= 1'b1;
                            state <= WB;
                        end else begin
                            cnt <= cnt - 6'd1;
                        end
                    end
                end
                WB: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!cancel && !div_zero) begin
                        if (hi_we) hi <= hi_val;
                        if (lo_we) lo <= lo_val;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
